// File: rtl/uart_rx_if.sv
// uart_rx_if: byte-stream output bundle of the UART receiver.
//   data      received byte, stable while valid=1
//   valid     data holds an unconsumed byte
//   ready     consumer accepts data when valid&&ready at a rising clk edge
//   frame_err one-cycle pulse, stop bit sampled low
//   overrun   one-cycle pulse, byte completed while previous byte unconsumed
// master = receiver side, slave = consumer side.
interface uart_rx_if;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       frame_err;
   logic       overrun;

   modport master (output data, valid, frame_err, overrun, input ready);
   modport slave  (input data, valid, frame_err, overrun, output ready);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, idle line high.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   rx   serial line, asynchronous to clk
//   bus  uart_rx_if.master: data/valid/ready handshake + frame_err/overrun pulses
module uart_rx #(
   parameter int CLK_FREQ = 8000000,
   parameter int BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   uart_rx_if.master  bus
);
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int HALF         = CLKS_PER_BIT / 2;
   localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [2:0]    idx, idx_nx;
   logic [7:0]    sh, sh_nx;
   logic [7:0]    data_q, data_nx;
   logic          valid_q, valid_nx;
   logic          ferr_q, ferr_nx;
   logic          ovr_q, ovr_nx;
   logic          s1, rx_s;

   wire mid  = (cnt == CW'(HALF));
   wire last = (cnt == CW'(CLKS_PER_BIT - 1));

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + CW'(1);
      idx_nx   = idx;
      sh_nx    = sh;
      data_nx  = data_q;
      valid_nx = valid_q & ~bus.ready;
      ferr_nx  = 1'b0;
      ovr_nx   = 1'b0;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (!rx_s) state_nx = START;
         end
         START: begin
            if (mid) begin
               // Restart the counter here so every later sample lands at
               // a bit centre, CLKS_PER_BIT clocks apart.
               cnt_nx = '0;
               idx_nx = '0;
               state_nx = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (last) begin
               cnt_nx = '0;
               sh_nx  = {rx_s, sh[7:1]};
               idx_nx = idx + 3'd1;
               if (idx == 3'd7) state_nx = STOP;
            end
         end
         STOP: begin
            if (last) begin
               cnt_nx = '0;
               if (rx_s) begin
                  // End of frame is taken at the stop-bit centre so a
                  // back-to-back start bit is never missed.
                  state_nx = IDLE;
                  if (!valid_q || bus.ready) begin
                     data_nx  = sh;
                     valid_nx = 1'b1;
                  end else begin
                     ovr_nx = 1'b1;
                  end
               end else begin
                  ferr_nx  = 1'b1;
                  state_nx = BRK;
               end
            end
         end
         BRK: begin
            // A held-low line must not be re-read as endless frames.
            cnt_nx = '0;
            if (rx_s) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         s1      <= 1'b1;
         rx_s    <= 1'b1;
         cnt     <= '0;
         idx     <= '0;
         sh      <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state   <= state_nx;
         s1      <= rx;
         rx_s    <= s1;
         cnt     <= cnt_nx;
         idx     <= idx_nx;
         sh      <= sh_nx;
         data_q  <= data_nx;
         valid_q <= valid_nx;
         ferr_q  <= ferr_nx;
         ovr_q   <= ovr_nx;
      end
   end

   assign bus.data      = data_q;
   assign bus.valid     = valid_q;
   assign bus.frame_err = ferr_q;
   assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx at 16 clks/bit; an event-level
// model (expected byte queue + expected error counts) is checked every cycle.
module tb_uart_rx;
   localparam int BIT = 160;   // 16 clks of period 10

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b1;
   uart_rx_if bus();

   uart_rx #(.CLK_FREQ(1600000), .BAUD(100000)) dut (
      .clk(clk), .rst(rst), .rx(rx), .bus(bus)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   // model state
   logic [7:0] exp_q[$];
   int exp_ferr = 0, exp_ovr = 0;
   bit held = 0;
   // observed
   int ferr_seen = 0, ovr_seen = 0;
   logic [7:0] last_data = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // What the receiver must do with one complete frame, given the
   // consumer state at the time it arrives.
   task automatic model_frame(input logic [7:0] b, input logic stop);
      if (!stop) exp_ferr++;
      else if (held && !bus.ready) exp_ovr++;
      else begin
         exp_q.push_back(b);
         if (!bus.ready) held = 1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input int bit_t, input logic stop);
      rx = 1'b0; #(bit_t);
      for (int i = 0; i < 8; i++) begin rx = b[i]; #(bit_t); end
      rx = stop; #(bit_t);
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1; #(n * BIT);
   endtask

   task automatic frame(input logic [7:0] b, input int bit_t);
      model_frame(b, 1'b1);
      send_frame(b, bit_t, 1'b1);
      idle_bits(2);
   endtask

   // per-cycle compare against the model
   logic pv = 0, pr = 0, prst = 1, pferr = 0, povr = 0;
   logic [7:0] pdata = 0;
   always @(negedge clk) begin
      if (!rst && !prst) begin
         if (bus.valid && (!pv || pr)) begin
            if (exp_q.size() == 0) begin
               chk_cnt++;
               $display("FAIL unexpected_valid: got data %0h expected no byte", bus.data);
            end else begin
               chk("data", {24'h0, bus.data}, {24'h0, exp_q.pop_front()});
            end
            last_data = bus.data;
         end else if (pv && !pr) begin
            chk("hold_valid", {31'h0, bus.valid}, 32'h1);
            chk("hold_data", {24'h0, bus.data}, {24'h0, pdata});
         end
         if (bus.frame_err) begin
            ferr_seen++;
            if (pferr) begin chk_cnt++; $display("FAIL ferr_width: got 2+ cycles expected 1"); end
         end
         if (bus.overrun) begin
            ovr_seen++;
            if (povr) begin chk_cnt++; $display("FAIL ovr_width: got 2+ cycles expected 1"); end
         end
      end
      pv = bus.valid; pr = bus.ready; prst = rst;
      pferr = bus.frame_err; povr = bus.overrun; pdata = bus.data;
   end

   task automatic chk_model(input string tag);
      chk({tag, "_queue"}, exp_q.size(), 0);
      chk({tag, "_ferr"}, ferr_seen, exp_ferr);
      chk({tag, "_ovr"}, ovr_seen, exp_ovr);
   endtask

   initial begin
      bus.ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", {31'h0, bus.valid}, 0);
      chk("rst_data", {24'h0, bus.data}, 0);
      chk("rst_ferr", {31'h0, bus.frame_err}, 0);
      chk("rst_ovr", {31'h0, bus.overrun}, 0);
      @(posedge clk); #1 rst = 1'b0;
      idle_bits(1);

      // plain frame, consumer ready
      frame(8'hAB, BIT);
      chk("t1_last", {24'h0, last_data}, 32'hAB);
      chk_model("t1");

      // consumer stalled: second frame overruns
      @(posedge clk); #1 bus.ready = 1'b0;
      model_frame(8'h55, 1'b1);
      send_frame(8'h55, BIT, 1'b1);
      model_frame(8'h0F, 1'b1);
      send_frame(8'h0F, BIT, 1'b1);
      idle_bits(2);
      @(negedge clk);
      chk("t2_valid", {31'h0, bus.valid}, 1);
      chk("t2_data", {24'h0, bus.data}, 32'h55);
      chk("t2_ovr_lit", ovr_seen, 1);
      @(posedge clk); #1 bus.ready = 1'b1; held = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("t2_drop", {31'h0, bus.valid}, 0);
      chk_model("t2");

      // bad stop bit followed by a long break
      model_frame(8'hC3, 1'b0);
      send_frame(8'hC3, BIT, 1'b0);
      #(40 * BIT);
      idle_bits(2);
      chk("t3_ferr_lit", ferr_seen, 1);
      frame(8'h3C, BIT);
      chk("t3_last", {24'h0, last_data}, 32'h3C);
      chk_model("t3");

      // short glitch
      @(posedge clk); #1 rx = 1'b0;
      repeat (4) @(posedge clk);
      #1 rx = 1'b1;
      idle_bits(2);
      chk_model("t4g");
      frame(8'h81, BIT);
      chk("t4_last", {24'h0, last_data}, 32'h81);
      chk_model("t4");

      // reset during bit 4 of 0xFF
      rx = 1'b0; #(BIT);
      rx = 1'b1; #(4 * BIT + BIT / 2);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("t5_valid", {31'h0, bus.valid}, 0);
      chk("t5_data", {24'h0, bus.data}, 0);
      chk("t5_ferr", {31'h0, bus.frame_err}, 0);
      chk("t5_ovr", {31'h0, bus.overrun}, 0);
      #(4 * BIT);
      idle_bits(12);
      chk_model("t5r");
      frame(8'h12, BIT);
      chk("t5_last", {24'h0, last_data}, 32'h12);
      chk_model("t5");

      // baud tolerance
      frame(8'hA5, 155);
      chk("t6_fast", {24'h0, last_data}, 32'hA5);
      last_data = 8'h00;
      frame(8'hA5, 165);
      chk("t6_slow", {24'h0, last_data}, 32'hA5);
      chk_model("t6");

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver paired with the team's uart_tx: 8N1 framing, LSB first, idle line high. Samples the asynchronous rx pin, recovers one byte per frame and presents it on a valid/ready output handshake. Sits between the board pin and the byte-stream consumer and runs in the same clock domain as uart_tx.

Parameters:
CLK_FREQ, 8000000, system clock frequency in Hz
BAUD, 115200, line bit rate in bits/s
CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, 69 at defaults), clocks per bit; derived, not overridden

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
rx  input  1  serial line, asynchronous to clk, idle high
data  output  8  received byte, stable while valid=1
valid  output  1  data holds an unconsumed byte
ready  input  1  consumer accepts data when valid&&ready at a rising clk edge
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: byte completed while previous byte still unconsumed

Behaviour:
- Reset, sampled at clk edge while rst=1: state=IDLE, data=8'h00, valid=0, frame_err=0, overrun=0, synchronizer flops=1, counters=0. Reset mid-frame aborts the frame; no output is produced for it.
- rx passes through a 2-flop synchronizer. rx_s denotes the second flop output. All decisions use rx_s.
- Baud counter: counts 0..CLKS_PER_BIT-1. A mid-bit sample occurs at count CLKS_PER_BIT/2 (34 at defaults, integer division).
- IDLE:
  - On rx_s=0, go to START and clear the counter.
- START:
  - At the mid-bit sample, if rx_s=1 (glitch), return to IDLE.
  - If rx_s=0, go to DATA. Bit index=0. The counter realigns so that subsequent samples fall at the centre of each bit, i.e. every CLKS_PER_BIT clocks.
- DATA:
  - At each centre sample, shift rx_s into the shift register as bit[index], LSB first.
  - After index 7, go to STOP.
- STOP, at the centre sample:
  - rx_s=1: go to IDLE (stop-bit centre accepted as end of frame; the second half of the stop bit is not waited for).
    - If valid=0, or valid=1 with ready=1 in the same cycle: load data, valid=1 on the next cycle.
    - Otherwise: pulse overrun for 1 cycle. Keep the old data/valid and drop the new byte.
  - rx_s=0: pulse frame_err for 1 cycle and discard the byte. Go to BREAK.
- BREAK: wait until rx_s=1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Handshake:
  - valid clears on the cycle after valid&&ready.
  - data never changes while valid=1, except for the simultaneous accept+load case above, where it is replaced by the new byte and valid stays 1.
- Latency: valid rises 1 clk after the stop-bit centre sample. That sample is 2 sync clocks plus ~9.5 bit periods after the rx falling edge.
- Back-to-back frames: the next start bit may begin immediately after the stop-bit centre. IDLE detects it with no dead time required.
- ready is ignored while valid=0.

Test Plan:
- Bench overrides CLK_FREQ=1600000, BAUD=100000 (CLKS_PER_BIT=16). Drive frame 0xAB (line bits 0,1,1,0,1,0,1,0,1,1) with ready=1 -> exactly one valid pulse with data=8'hAB; frame_err=0, overrun=0.
- ready=0; send 0x55 then 0x0F back-to-back -> valid stays 1, data=8'h55, overrun pulses once at the second stop-bit sample. Then raise ready -> valid drops the next cycle and 0x0F is never presented.
- Send 0xC3 with stop bit driven 0, then hold rx low for 40 bit times, then release high -> one frame_err pulse, no valid, no further frames while low. A following 0x3C is received correctly.
- rx low for 4 clks (shorter than half a bit), then high -> stays IDLE: no valid, no frame_err. A following 0x81 is received correctly.
- Assert rst for 1 clk during bit 4 of frame 0xFF -> all outputs 0. The remaining bits cause no valid and no errors (any low data bit restarts as a glitch or an error frame). After a 12-bit idle gap, 0x12 is received correctly.
- Baud tolerance: transmit 0xA5 at ±3% bit period (15.5/16.5 clks) -> data=8'hA5 in both cases.
